// File: rtl/escalonador_turnos.sv
// escalonador_turnos
// Two-player turn scheduler sitting in front of the shared move datapath.
// It grants the single jogada path to the player whose turn it is and keeps
// one chess-clock budget per player. Moves go to the game control unit one
// at a time through a temJogada/ack handshake. A sticky per-player flag is
// raised when that player's budget runs out.
//
// Ports
//   clock      in   system clock, all state on rising edge
//   reset      in   synchronous active-high reset, returns to OCIOSO
//   iniciar    in   start a game (only looked at in OCIOSO)
//   terminar   in   leave FIM (only looked at in FIM)
//   reqA/reqB  in   player has a move on jogadaA/jogadaB
//   jogadaA/B  in   player moves (square index)
//   ack        in   control unit consumed the presented move
//   temJogada  out  jogada valid, held until ack
//   jogada     out  granted move, holds its last value when not valid
//   vezB       out  0 = A's turn, 1 = B's turn
//   fimA/fimB  out  player timed out, sticky until OCIOSO
//   tempoA/B   out  remaining ticks per player
//   db_estado  out  current state code
//
// state   | code | meaning
// OCIOSO  | 0    | idle, waiting for iniciar
// CARREGA | 1    | load both budgets, clear flags
// VEZ_A   | 2    | A's turn, A's clock runs
// ENVIA_A | 3    | A's move presented, clocks frozen
// VEZ_B   | 4    | B's turn, B's clock runs
// ENVIA_B | 5    | B's move presented, clocks frozen
// FIM     | F    | game over, budgets frozen for display

module escalonador_turnos #(
  parameter int TEMPO_MAX = 30,
  parameter int TICK_DIV  = 1000,
  parameter int WJ        = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          terminar,
  input  logic          reqA,
  input  logic          reqB,
  input  logic [WJ-1:0] jogadaA,
  input  logic [WJ-1:0] jogadaB,
  input  logic          ack,
  output logic          temJogada,
  output logic [WJ-1:0] jogada,
  output logic          vezB,
  output logic          fimA,
  output logic          fimB,
  output logic [7:0]    tempoA,
  output logic [7:0]    tempoB,
  output logic [3:0]    db_estado
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [7:0]    TEMPO_INI = 8'(TEMPO_MAX);

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    CARREGA = 4'h1,
    VEZ_A   = 4'h2,
    ENVIA_A = 4'h3,
    VEZ_B   = 4'h4,
    ENVIA_B = 4'h5,
    FIM     = 4'hF
  } estado_t;

  estado_t       estado;
  logic [PW-1:0] presc;
  logic          relogio_ativo;
  logic          tick;

  // The prescaler only runs while a player is thinking.
  always_comb begin
    relogio_ativo = (estado == VEZ_A) || (estado == VEZ_B);
    tick          = relogio_ativo && (presc == PRESC_TOP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      presc     <= '0;
      temJogada <= 1'b0;
      jogada    <= '0;
      vezB      <= 1'b0;
      fimA      <= 1'b0;
      fimB      <= 1'b0;
      tempoA    <= 8'd0;
      tempoB    <= 8'd0;
    end else begin
      if (relogio_ativo) begin
        presc <= tick ? '0 : presc + PW'(1);
      end

      // Budget decrement saturates; the timeout decision below looks at the
      // registered budget, so FIM follows one cycle after it reaches zero.
      if (tick && estado == VEZ_A && tempoA != 8'd0) tempoA <= tempoA - 8'd1;
      if (tick && estado == VEZ_B && tempoB != 8'd0) tempoB <= tempoB - 8'd1;

      case (estado)
        OCIOSO: begin
          if (iniciar) estado <= CARREGA;
        end
        CARREGA: begin
          tempoA <= TEMPO_INI;
          tempoB <= TEMPO_INI;
          presc  <= '0;
          vezB   <= 1'b0;
          fimA   <= 1'b0;
          fimB   <= 1'b0;
          estado <= VEZ_A;
        end
        VEZ_A: begin
          if (tempoA == 8'd0) begin
            fimA   <= 1'b1;
            estado <= FIM;
          end else if (reqA) begin
            jogada    <= jogadaA;
            temJogada <= 1'b1;
            estado    <= ENVIA_A;
          end
        end
        ENVIA_A: begin
          if (ack) begin
            temJogada <= 1'b0;
            vezB      <= 1'b1;
            presc     <= '0;
            estado    <= VEZ_B;
          end
        end
        VEZ_B: begin
          if (tempoB == 8'd0) begin
            fimB   <= 1'b1;
            estado <= FIM;
          end else if (reqB) begin
            jogada    <= jogadaB;
            temJogada <= 1'b1;
            estado    <= ENVIA_B;
          end
        end
        ENVIA_B: begin
          if (ack) begin
            temJogada <= 1'b0;
            vezB      <= 1'b0;
            presc     <= '0;
            estado    <= VEZ_A;
          end
        end
        FIM: begin
          temJogada <= 1'b0;
          if (terminar) begin
            fimA   <= 1'b0;
            fimB   <= 1'b0;
            estado <= OCIOSO;
          end
        end
        default: begin
          temJogada <= 1'b0;
          estado    <= OCIOSO;
        end
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_escalonador_turnos.sv
// Directed bench for escalonador_turnos with TICK_DIV=4, TEMPO_MAX=3.
module tb_escalonador_turnos;

  localparam int WJ = 6;

  logic          clock = 1'b0;
  logic          reset, iniciar, terminar, reqA, reqB, ack;
  logic [WJ-1:0] jogadaA, jogadaB;
  logic          temJogada, vezB, fimA, fimB;
  logic [WJ-1:0] jogada;
  logic [7:0]    tempoA, tempoB;
  logic [3:0]    db_estado;

  int errors = 0;
  int checks = 0;

  escalonador_turnos #(.TEMPO_MAX(3), .TICK_DIV(4), .WJ(WJ)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .terminar(terminar),
    .reqA(reqA), .reqB(reqB), .jogadaA(jogadaA), .jogadaB(jogadaB),
    .ack(ack), .temJogada(temJogada), .jogada(jogada), .vezB(vezB),
    .fimA(fimA), .fimB(fimB), .tempoA(tempoA), .tempoB(tempoB),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_game();
    reset = 1'b1; tick();
    reset = 1'b0; iniciar = 1'b1; tick();
    iniciar = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    checks++;
    if (db_estado !== 4'h0) begin
      errors++; $display("FAIL reset_db got=%h exp=0", db_estado);
    end
    checks++;
    if ({temJogada, jogada, vezB, fimA, fimB, tempoA, tempoB} !== '0) begin
      errors++; $display("FAIL reset_outputs temJogada=%b jogada=%0d vezB=%b fimA=%b fimB=%b tempoA=%0d tempoB=%0d exp all 0",
                         temJogada, jogada, vezB, fimA, fimB, tempoA, tempoB);
    end
    reset = 1'b0;
  endtask

  task automatic test_start();
    iniciar = 1'b1; tick();
    checks++;
    if (db_estado !== 4'h1) begin
      errors++; $display("FAIL start_carrega got=%h exp=1", db_estado);
    end
    iniciar = 1'b0; tick();
    checks++;
    if (db_estado !== 4'h2 || tempoA !== 8'd3 || tempoB !== 8'd3 || vezB !== 1'b0) begin
      errors++; $display("FAIL start_veza db=%h tempoA=%0d tempoB=%0d vezB=%b exp db=2 3 3 0",
                         db_estado, tempoA, tempoB, vezB);
    end
  endtask

  task automatic test_handshake();
    // ack and reqB during A's turn are ignored
    ack = 1'b1; reqB = 1'b1; jogadaB = 6'd33; tick();
    checks++;
    if (db_estado !== 4'h2 || temJogada !== 1'b0) begin
      errors++; $display("FAIL stray_ack_reqB db=%h temJogada=%b exp db=2 0", db_estado, temJogada);
    end
    ack = 1'b0; reqA = 1'b1; jogadaA = 6'd12; tick();
    checks++;
    if (db_estado !== 4'h3 || temJogada !== 1'b1 || jogada !== 6'd12) begin
      errors++; $display("FAIL capture_a db=%h temJogada=%b jogada=%0d exp db=3 1 12",
                         db_estado, temJogada, jogada);
    end
    reqA = 1'b0; jogadaA = 6'd50;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (db_estado !== 4'h3 || temJogada !== 1'b1 || jogada !== 6'd12) begin
        errors++; $display("FAIL hold_a cycle=%0d db=%h temJogada=%b jogada=%0d exp db=3 1 12",
                           i, db_estado, temJogada, jogada);
      end
    end
    checks++;
    if (tempoA !== 8'd3) begin
      errors++; $display("FAIL frozen_a tempoA=%0d exp=3", tempoA);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++;
    if (db_estado !== 4'h4 || vezB !== 1'b1 || temJogada !== 1'b0 || jogada !== 6'd12) begin
      errors++; $display("FAIL ack_a db=%h vezB=%b temJogada=%b jogada=%0d exp db=4 1 0 12",
                         db_estado, vezB, temJogada, jogada);
    end
    tick();
    checks++;
    if (db_estado !== 4'h5 || temJogada !== 1'b1 || jogada !== 6'd33) begin
      errors++; $display("FAIL capture_b db=%h temJogada=%b jogada=%0d exp db=5 1 33",
                         db_estado, temJogada, jogada);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++;
    if (db_estado !== 4'h2 || vezB !== 1'b0 || temJogada !== 1'b0) begin
      errors++; $display("FAIL ack_b db=%h vezB=%b temJogada=%b exp db=2 0 0", db_estado, vezB, temJogada);
    end
    tick();
    checks++;
    if (db_estado !== 4'h2 || temJogada !== 1'b0 || jogada !== 6'd33) begin
      errors++; $display("FAIL held_reqB db=%h temJogada=%b jogada=%0d exp db=2 0 33",
                         db_estado, temJogada, jogada);
    end
    reqB = 1'b0;
    checks++;
    if (tempoA !== 8'd3 || tempoB !== 8'd3) begin
      errors++; $display("FAIL budgets_after_moves tempoA=%0d tempoB=%0d exp 3 3", tempoA, tempoB);
    end
  endtask

  task automatic test_timeout_a();
    start_game();
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k % 4 == 0) begin
        checks++;
        if (tempoA !== 8'(3 - k / 4)) begin
          errors++; $display("FAIL count_a k=%0d tempoA=%0d exp=%0d", k, tempoA, 3 - k / 4);
        end
      end
    end
    checks++;
    if (db_estado !== 4'h2) begin
      errors++; $display("FAIL before_fim_a db=%h exp=2", db_estado);
    end
    tick();
    checks++;
    if (db_estado !== 4'hF || fimA !== 1'b1 || fimB !== 1'b0 || tempoA !== 8'd0 ||
        tempoB !== 8'd3 || temJogada !== 1'b0) begin
      errors++; $display("FAIL fim_a db=%h fimA=%b fimB=%b tempoA=%0d tempoB=%0d temJogada=%b exp F 1 0 0 3 0",
                         db_estado, fimA, fimB, tempoA, tempoB, temJogada);
    end
    tick(); tick();
    checks++;
    if (db_estado !== 4'hF || fimA !== 1'b1 || tempoB !== 8'd3) begin
      errors++; $display("FAIL fim_hold db=%h fimA=%b tempoB=%0d exp F 1 3", db_estado, fimA, tempoB);
    end
    terminar = 1'b1; tick(); terminar = 1'b0;
    checks++;
    if (db_estado !== 4'h0 || fimA !== 1'b0) begin
      errors++; $display("FAIL terminar db=%h fimA=%b exp 0 0", db_estado, fimA);
    end
  endtask

  task automatic test_timeout_with_req();
    start_game();
    repeat (12) tick();
    reqA = 1'b1; jogadaA = 6'd7; tick();
    checks++;
    if (db_estado !== 4'hF || temJogada !== 1'b0 || jogada !== 6'd0 || fimA !== 1'b1) begin
      errors++; $display("FAIL timeout_vs_req db=%h temJogada=%b jogada=%0d fimA=%b exp F 0 0 1",
                         db_estado, temJogada, jogada, fimA);
    end
    tick(); reqA = 1'b0;
    checks++;
    if (temJogada !== 1'b0 || db_estado !== 4'hF) begin
      errors++; $display("FAIL timeout_vs_req_hold db=%h temJogada=%b exp F 0", db_estado, temJogada);
    end
  endtask

  task automatic test_timeout_b();
    start_game();
    reqA = 1'b1; jogadaA = 6'd20; tick(); reqA = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) begin
        checks++;
        if (tempoB !== 8'd2) begin
          errors++; $display("FAIL count_b k=4 tempoB=%0d exp=2", tempoB);
        end
      end
    end
    checks++;
    if (tempoB !== 8'd0 || tempoA !== 8'd3 || db_estado !== 4'h4) begin
      errors++; $display("FAIL before_fim_b tempoB=%0d tempoA=%0d db=%h exp 0 3 4", tempoB, tempoA, db_estado);
    end
    tick();
    checks++;
    if (db_estado !== 4'hF || fimB !== 1'b1 || fimA !== 1'b0 || vezB !== 1'b1 || jogada !== 6'd20) begin
      errors++; $display("FAIL fim_b db=%h fimB=%b fimA=%b vezB=%b jogada=%0d exp F 1 0 1 20",
                         db_estado, fimB, fimA, vezB, jogada);
    end
  endtask

  task automatic test_reset_mid_game();
    start_game();
    reqA = 1'b1; jogadaA = 6'd5; tick(); reqA = 1'b0;
    ack = 1'b1; tick(); ack = 1'b0;
    reqB = 1'b1; jogadaB = 6'd9; tick(); reqB = 1'b0;
    checks++;
    if (db_estado !== 4'h5 || temJogada !== 1'b1 || jogada !== 6'd9 || vezB !== 1'b1) begin
      errors++; $display("FAIL envia_b db=%h temJogada=%b jogada=%0d vezB=%b exp 5 1 9 1",
                         db_estado, temJogada, jogada, vezB);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (db_estado !== 4'h0 ||
        {temJogada, jogada, vezB, fimA, fimB, tempoA, tempoB} !== '0) begin
      errors++; $display("FAIL mid_reset db=%h temJogada=%b jogada=%0d vezB=%b tempoA=%0d tempoB=%0d exp all 0",
                         db_estado, temJogada, jogada, vezB, tempoA, tempoB);
    end
    tick();
    checks++;
    if (db_estado !== 4'h0) begin
      errors++; $display("FAIL idle_stays db=%h exp=0", db_estado);
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; terminar = 1'b0;
    reqA = 1'b0; reqB = 1'b0; ack = 1'b0;
    jogadaA = '0; jogadaB = '0;
    test_reset();
    test_start();
    test_handshake();
    test_timeout_a();
    test_timeout_with_req();
    test_timeout_b();
    test_reset_mid_game();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
